// File: rtl/accum_ctrl_pkg.sv
// accum_ctrl_pkg
// Shared definitions for the accumulator loop controller: FSM state
// encoding, vote/run counter widths, step limits and the gear-shift helper.
// No ports (package).
package accum_ctrl_pkg;

  // Controller states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESET = 3'd1;
  localparam logic [2:0] ST_ACQ    = 3'd2;
  localparam logic [2:0] ST_TRACK  = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  // Vote counter must hold +/-64 (largest window); decision counter 0..63
  localparam int VOTE_W = 8;
  localparam int CNT_W  = 7;
  // Run counter only needs to reach LOSS_CNT (max 15)
  localparam int RUN_W  = 4;

  localparam logic [3:0]  STEP_MIN      = 4'd1;
  localparam logic [3:0]  STEP_MAX      = 4'd15;
  localparam logic [15:0] EXT_RESET_VAL = 16'h8000;

  // Halve the step on a direction reversal, never going below one LSB
  function automatic logic [3:0] gear_down(input logic [3:0] s);
    logic [3:0] h;
    h = s >> 1;
    return (h < STEP_MIN) ? STEP_MIN : h;
  endfunction

  // Guard against a zero or out-of-range initial step
  function automatic logic [3:0] legal_step(input logic [3:0] s);
    if (s < STEP_MIN) return STEP_MIN;
    if (s > STEP_MAX) return STEP_MAX;
    return s;
  endfunction

endpackage

// File: rtl/accum_track_vote.sv
// accum_track_vote
// Decimating signed vote counter for TRACK mode. Each qualified decision adds
// +1 (comp=1) or -1 (comp=0). The decision that completes a window of DECIM
// decisions raises done in that same cycle, with dir_up/zero describing the
// final vote including that decision; the counter then restarts.
// Ports:
//   clk, rstb : clock, async active-low reset
//   clear     : discard the current partial window
//   valid     : a decision to count this cycle
//   comp      : decision value
//   done      : window completes with this decision (combinational)
//   dir_up    : window vote is positive
//   zero      : window vote is exactly zero
module accum_track_vote
  import accum_ctrl_pkg::*;
#(
  parameter int DECIM = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic clear,
  input  logic valid,
  input  logic comp,
  output logic done,
  output logic dir_up,
  output logic zero
);

  localparam logic [CNT_W-1:0]         LAST      = CNT_W'(DECIM - 1);
  localparam logic signed [VOTE_W-1:0] VOTE_ONE  = VOTE_W'(1);
  localparam logic signed [VOTE_W-1:0] VOTE_ZERO = '0;

  logic [CNT_W-1:0]         cnt;
  logic signed [VOTE_W-1:0] vote;
  logic signed [VOTE_W-1:0] vote_next;

  // The result looks ahead to include the current decision so the top can
  // register its pulse with single-cycle latency.
  always_comb begin
    vote_next = comp ? (vote + VOTE_ONE) : (vote - VOTE_ONE);
    done      = valid && (cnt == LAST);
    dir_up    = (vote_next > VOTE_ZERO);
    zero      = (vote_next == VOTE_ZERO);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt  <= '0;
      vote <= '0;
    end else if (clear || done) begin
      cnt  <= '0;
      vote <= '0;
    end else if (valid) begin
      cnt  <= cnt + CNT_W'(1);
      vote <= vote_next;
    end
  end

endmodule

// File: rtl/accum_loop_ctrl.sv
// accum_loop_ctrl
// Sequences the 16-bit step accumulator from a comparator decision stream:
// preset load, gear-shifted binary acquisition, then majority-voted tracking
// with lock/loss detection. All outputs are registered.
// Ports:
//   clk, rstb    : clock, async active-low reset
//   start        : pulse; capture preset_val and restart acquisition
//   freeze       : level; hold the loop (ACQ/TRACK only)
//   comp         : 1 = code too low (step up)
//   comp_valid   : one-cycle strobe qualifying comp
//   preset_val   : preset code sampled with start
//   acc_enable   : one-cycle accumulator update pulse
//   acc_up       : update direction
//   acc_step     : update step size
//   acc_sel_ext  : load acc_ext_val instead of stepping
//   acc_ext_val  : preset value for the accumulator
//   locked       : loop is tracking
//   busy         : controller has left IDLE
module accum_loop_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter logic [3:0] STEP_INIT   = 4'd8,
  parameter int         LOCK_CNT    = 4,
  parameter int         TRACK_DECIM = 8,
  parameter int         LOSS_CNT    = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        start,
  input  logic        freeze,
  input  logic        comp,
  input  logic        comp_valid,
  input  logic [15:0] preset_val,
  output logic        acc_enable,
  output logic        acc_up,
  output logic [3:0]  acc_step,
  output logic        acc_sel_ext,
  output logic [15:0] acc_ext_val,
  output logic        locked,
  output logic        busy
);

  localparam logic [3:0]       STEP_START = legal_step(STEP_INIT);
  localparam logic [3:0]       LOCK_N     = 4'(LOCK_CNT);
  localparam logic [RUN_W-1:0] LOSS_N     = RUN_W'(LOSS_CNT);

  logic [2:0]       state;
  logic [2:0]       saved_state;
  logic [3:0]       step;
  logic [3:0]       rev_cnt;
  logic             prev_valid;
  logic             prev_dir;
  logic [RUN_W-1:0] run_cnt;
  logic             run_dir;

  logic             acq_take;
  logic             track_take;
  logic             reversal;
  logic [3:0]       acq_step;
  logic [3:0]       rev_cnt_inc;
  logic             lock_hit;
  logic [RUN_W-1:0] run_next;
  logic             loss_hit;
  logic             vote_clear;
  logic             vote_done;
  logic             vote_up;
  logic             vote_zero;

  // Decisions only count when neither start nor freeze overrides them.
  // The step is halved before use on a reversal; a reversal only advances
  // the lock count when the step was already at its minimum.
  always_comb begin
    acq_take    = (state == ST_ACQ)   && comp_valid && !freeze && !start;
    track_take  = (state == ST_TRACK) && comp_valid && !freeze && !start;
    reversal    = prev_valid && (comp != prev_dir);
    acq_step    = reversal ? gear_down(step) : step;
    rev_cnt_inc = rev_cnt + 4'd1;
    lock_hit    = acq_take && reversal && (step == STEP_MIN) && (rev_cnt_inc == LOCK_N);
    run_next    = ((run_cnt != '0) && (run_dir == vote_up)) ? (run_cnt + RUN_W'(1)) : RUN_W'(1);
    loss_hit    = vote_done && !vote_zero && (run_next == LOSS_N);
    vote_clear  = start || lock_hit;
  end

  accum_track_vote #(
    .DECIM (TRACK_DECIM)
  ) u_vote (
    .clk    (clk),
    .rstb   (rstb),
    .clear  (vote_clear),
    .valid  (track_take),
    .comp   (comp),
    .done   (vote_done),
    .dir_up (vote_up),
    .zero   (vote_zero)
  );

  // Main FSM and output registers. The pulse flags default low every cycle;
  // direction, step and preset value hold between pulses.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      saved_state <= ST_ACQ;
      step        <= STEP_START;
      rev_cnt     <= '0;
      prev_valid  <= 1'b0;
      prev_dir    <= 1'b0;
      run_cnt     <= '0;
      run_dir     <= 1'b0;
      acc_enable  <= 1'b0;
      acc_up      <= 1'b0;
      acc_step    <= 4'd0;
      acc_sel_ext <= 1'b0;
      acc_ext_val <= EXT_RESET_VAL;
      locked      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      acc_enable  <= 1'b0;
      acc_sel_ext <= 1'b0;
      if (start) begin
        state       <= ST_PRESET;
        busy        <= 1'b1;
        locked      <= 1'b0;
        acc_enable  <= 1'b1;
        acc_sel_ext <= 1'b1;
        acc_ext_val <= preset_val;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_PRESET: begin
            state      <= ST_ACQ;
            step       <= STEP_START;
            rev_cnt    <= '0;
            prev_valid <= 1'b0;
          end
          ST_ACQ: begin
            if (freeze) begin
              saved_state <= ST_ACQ;
              state       <= ST_HOLD;
            end else if (acq_take) begin
              acc_enable <= 1'b1;
              acc_up     <= comp;
              acc_step   <= acq_step;
              step       <= acq_step;
              prev_valid <= 1'b1;
              prev_dir   <= comp;
              if (step == STEP_MIN) begin
                rev_cnt <= reversal ? rev_cnt_inc : 4'd0;
              end
              if (lock_hit) begin
                state   <= ST_TRACK;
                locked  <= 1'b1;
                run_cnt <= '0;
                run_dir <= 1'b0;
              end
            end
          end
          ST_TRACK: begin
            if (freeze) begin
              saved_state <= ST_TRACK;
              state       <= ST_HOLD;
            end else if (vote_done) begin
              if (vote_zero) begin
                run_cnt <= '0;
              end else begin
                acc_enable <= 1'b1;
                acc_up     <= vote_up;
                acc_step   <= STEP_MIN;
                run_dir    <= vote_up;
                if (loss_hit) begin
                  state      <= ST_ACQ;
                  locked     <= 1'b0;
                  step       <= STEP_START;
                  rev_cnt    <= '0;
                  prev_valid <= 1'b0;
                  run_cnt    <= '0;
                end else begin
                  run_cnt <= run_next;
                end
              end
            end
          end
          ST_HOLD: begin
            if (!freeze) begin
              state <= saved_state;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accum_loop_ctrl.sv
// tb_accum_loop_ctrl
// Self-checking bench for accum_loop_ctrl: directed scenarios plus a
// randomized run, all compared against a behavioural model of the loop.
module tb_accum_loop_ctrl;

  localparam int STEP_INIT   = 8;
  localparam int LOCK_CNT    = 4;
  localparam int TRACK_DECIM = 8;
  localparam int LOSS_CNT    = 4;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0;
  logic        freeze = 1'b0;
  logic        comp = 1'b0;
  logic        comp_valid = 1'b0;
  logic [15:0] preset_val = 16'h0000;
  logic        acc_enable;
  logic        acc_up;
  logic [3:0]  acc_step;
  logic        acc_sel_ext;
  logic [15:0] acc_ext_val;
  logic        locked;
  logic        busy;

  int total = 0;
  int bad   = 0;

  accum_loop_ctrl #(
    .STEP_INIT   (4'(STEP_INIT)),
    .LOCK_CNT    (LOCK_CNT),
    .TRACK_DECIM (TRACK_DECIM),
    .LOSS_CNT    (LOSS_CNT)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .start       (start),
    .freeze      (freeze),
    .comp        (comp),
    .comp_valid  (comp_valid),
    .preset_val  (preset_val),
    .acc_enable  (acc_enable),
    .acc_up      (acc_up),
    .acc_step    (acc_step),
    .acc_sel_ext (acc_sel_ext),
    .acc_ext_val (acc_ext_val),
    .locked      (locked),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model of the loop
  typedef enum {M_IDLE, M_PRESET, M_ACQ, M_TRACK, M_HOLD} mstate_t;
  mstate_t ms;
  mstate_t m_saved;
  int m_step, m_rev, m_prev, m_votes, m_nvotes, m_run, m_rundir;
  logic        e_en, e_up, e_sel, e_lock, e_busy;
  logic [3:0]  e_step;
  logic [15:0] e_ext;

  localparam logic [24:0] RESET_VEC = {1'b0, 1'b0, 4'd0, 1'b0, 16'h8000, 1'b0, 1'b0};

  function automatic logic [24:0] dut_vec();
    return {acc_enable, acc_up, acc_step, acc_sel_ext, acc_ext_val, locked, busy};
  endfunction

  function automatic logic [24:0] exp_vec();
    return {e_en, e_up, e_step, e_sel, e_ext, e_lock, e_busy};
  endfunction

  task automatic model_reset();
    ms = M_IDLE; m_saved = M_ACQ;
    m_step = STEP_INIT; m_rev = 0; m_prev = -1;
    m_votes = 0; m_nvotes = 0; m_run = 0; m_rundir = 0;
    e_en = 0; e_up = 0; e_step = 4'd0; e_sel = 0; e_ext = 16'h8000; e_lock = 0; e_busy = 0;
  endtask

  task automatic model_step(input logic st, input logic fr, input logic cv,
                            input logic c, input logic [15:0] pv);
    bit rev, was1;
    int d;
    e_en = 0;
    e_sel = 0;
    if (st) begin
      ms = M_PRESET; e_en = 1; e_sel = 1; e_ext = pv; e_lock = 0;
      m_votes = 0; m_nvotes = 0;
    end else begin
      case (ms)
        M_IDLE: ;
        M_PRESET: begin
          ms = M_ACQ; m_step = STEP_INIT; m_rev = 0; m_prev = -1;
        end
        M_ACQ: begin
          if (fr) begin
            m_saved = M_ACQ; ms = M_HOLD;
          end else if (cv) begin
            rev  = (m_prev != -1) && (int'(c) != m_prev);
            was1 = (m_step == 1);
            if (rev) m_step = (m_step / 2 > 1) ? m_step / 2 : 1;
            e_en = 1; e_up = c; e_step = 4'(m_step); m_prev = int'(c);
            if (was1) m_rev = rev ? m_rev + 1 : 0;
            if (m_rev == LOCK_CNT) begin
              ms = M_TRACK; e_lock = 1; m_votes = 0; m_nvotes = 0; m_run = 0;
            end
          end
        end
        M_TRACK: begin
          if (fr) begin
            m_saved = M_TRACK; ms = M_HOLD;
          end else if (cv) begin
            m_votes += c ? 1 : -1;
            m_nvotes++;
            if (m_nvotes == TRACK_DECIM) begin
              if (m_votes == 0) begin
                m_run = 0;
              end else begin
                d = (m_votes > 0) ? 1 : 0;
                e_en = 1; e_up = d[0]; e_step = 4'd1;
                m_run = (m_run > 0 && d == m_rundir) ? m_run + 1 : 1;
                m_rundir = d;
                if (m_run == LOSS_CNT) begin
                  ms = M_ACQ; e_lock = 0; m_step = STEP_INIT; m_rev = 0; m_prev = -1; m_run = 0;
                end
              end
              m_votes = 0; m_nvotes = 0;
            end
          end
        end
        M_HOLD: begin
          if (!fr) ms = m_saved;
        end
        default: ;
      endcase
    end
    e_busy = (ms != M_IDLE);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit
  task automatic tick(input logic st, input logic fr, input logic cv,
                      input logic c, input logic [15:0] pv);
    start = st; freeze = fr; comp_valid = cv; comp = c; preset_val = pv;
    @(posedge clk);
    model_step(st, fr, cv, c, pv);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++; $display("[TB] FAIL reset_values got=%h want=%h", dut_vec(), RESET_VEC);
    end
    @(negedge clk);
    rstb = 1'b1;
    tick(0, 1, 1, 1, 16'hFFFF);
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++; $display("[TB] FAIL idle_ignores got=%h want=%h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_preset();
    tick(1, 0, 0, 0, 16'h1234);
    total++;
    if (acc_enable !== 1'b1 || acc_sel_ext !== 1'b1 || acc_ext_val !== 16'h1234 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL preset_pulse got en=%b sel=%b ext=%h busy=%b want 1 1 1234 1",
                      acc_enable, acc_sel_ext, acc_ext_val, busy);
    end
    tick(0, 0, 0, 0, 16'h5555);
    total++;
    if (acc_sel_ext !== 1'b0 || acc_enable !== 1'b0 || busy !== 1'b1 || acc_ext_val !== 16'h1234) begin
      bad++; $display("[TB] FAIL preset_after got en=%b sel=%b ext=%h busy=%b want 0 0 1234 1",
                      acc_enable, acc_sel_ext, acc_ext_val, busy);
    end
  endtask

  task automatic test_acq_gear();
    logic seq [5]   = '{1, 1, 0, 1, 0};
    int   steps [5] = '{8, 8, 4, 2, 1};
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, seq[i], 16'h0);
      total++;
      if (acc_enable !== 1'b1 || acc_up !== seq[i] || acc_step !== 4'(steps[i])) begin
        bad++; $display("[TB] FAIL acq_gear[%0d] got en=%b up=%b step=%0d want 1 %b %0d",
                        i, acc_enable, acc_up, acc_step, seq[i], steps[i]);
      end
      tick(0, 0, 0, ~seq[i], 16'h0);
      total++;
      if (dut_vec() !== exp_vec() || acc_enable !== 1'b0) begin
        bad++; $display("[TB] FAIL acq_hold[%0d] got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lock();
    for (int j = 0; j < 4; j++) begin
      tick(0, 0, 1, (j % 2 == 0), 16'h0);
      total++;
      if (acc_step !== 4'd1 || locked !== (j == 3) || dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL lock_rev[%0d] got step=%0d locked=%b want 1 %b",
                        j, acc_step, locked, (j == 3));
      end
    end
  endtask

  task automatic test_track_vote();
    logic win_a [8] = '{1, 0, 1, 1, 1, 0, 1, 1};
    logic win_b [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 1, win_a[i], 16'h0);
      total++;
      if (acc_enable !== (i == 7) || dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL vote_up[%0d] got en=%b want %b vec=%h model=%h",
                        i, acc_enable, (i == 7), dut_vec(), exp_vec());
      end
      tick(0, 0, 0, 1, 16'h0);
    end
    total++;
    if (acc_up !== 1'b1 || acc_step !== 4'd1 || locked !== 1'b1) begin
      bad++; $display("[TB] FAIL vote_up_dir got up=%b step=%0d locked=%b want 1 1 1",
                      acc_up, acc_step, locked);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 1, win_b[i], 16'h0);
      total++;
      if (acc_enable !== 1'b0 || dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL vote_tie[%0d] got en=%b want 0", i, acc_enable);
      end
    end
  endtask

  task automatic test_loss();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < TRACK_DECIM; i++) tick(0, 0, 1, 1, 16'h0);
      total++;
      if (acc_enable !== 1'b1 || acc_up !== 1'b1 || locked !== (k != 3)) begin
        bad++; $display("[TB] FAIL loss_window[%0d] got en=%b up=%b locked=%b want 1 1 %b",
                        k, acc_enable, acc_up, locked, (k != 3));
      end
    end
    tick(0, 0, 1, 0, 16'h0);
    total++;
    if (acc_enable !== 1'b1 || acc_step !== 4'd8 || acc_up !== 1'b0) begin
      bad++; $display("[TB] FAIL loss_reacq got en=%b step=%0d up=%b want 1 8 0",
                      acc_enable, acc_step, acc_up);
    end
  endtask

  task automatic test_freeze();
    tick(0, 0, 1, 1, 16'h0);
    tick(0, 0, 1, 0, 16'h0);
    total++;
    if (acc_step !== 4'd2) begin
      bad++; $display("[TB] FAIL freeze_setup got step=%0d want 2", acc_step);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1, 1, 16'h0);
      total++;
      if (acc_enable !== 1'b0 || dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL freeze_hold[%0d] got en=%b want 0", i, acc_enable);
      end
    end
    tick(0, 0, 0, 0, 16'h0);
    tick(0, 0, 1, 0, 16'h0);
    total++;
    if (acc_enable !== 1'b1 || acc_step !== 4'd2 || acc_up !== 1'b0) begin
      bad++; $display("[TB] FAIL freeze_release got en=%b step=%0d up=%b want 1 2 0",
                      acc_enable, acc_step, acc_up);
    end
  endtask

  task automatic test_start_mid_track();
    logic seq [5] = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) tick(0, 0, 1, seq[i], 16'h0);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("[TB] FAIL relock got locked=%b want 1", locked);
    end
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 16'h0);
    tick(1, 0, 1, 1, 16'hBEEF);
    total++;
    if (acc_enable !== 1'b1 || acc_sel_ext !== 1'b1 || acc_ext_val !== 16'hBEEF || locked !== 1'b0) begin
      bad++; $display("[TB] FAIL restart got en=%b sel=%b ext=%h locked=%b want 1 1 beef 0",
                      acc_enable, acc_sel_ext, acc_ext_val, locked);
    end
    tick(0, 0, 0, 0, 16'h0);
    tick(0, 0, 1, 1, 16'h0);
    total++;
    if (acc_enable !== 1'b1 || acc_step !== 4'd8 || dut_vec() !== exp_vec()) begin
      bad++; $display("[TB] FAIL restart_acq got en=%b step=%0d want 1 8", acc_enable, acc_step);
    end
  endtask

  task automatic test_reset_abort();
    comp_valid = 1'b1; comp = 1'b0;
    @(negedge clk);
    rstb = 1'b0;
    #1;
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++; $display("[TB] FAIL reset_abort got=%h want=%h", dut_vec(), RESET_VEC);
    end
    model_reset();
    @(posedge clk);
    #1;
    total++;
    if (acc_enable !== 1'b0 || dut_vec() !== exp_vec()) begin
      bad++; $display("[TB] FAIL reset_drop got=%h want=%h", dut_vec(), exp_vec());
    end
    comp_valid = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_random();
    logic fr = 1'b0;
    int bias = 5;
    tick(1, 0, 0, 0, 16'($urandom));
    for (int n = 0; n < 3000; n++) begin
      logic st, cv, c;
      if (n % 150 == 0) bias = $urandom_range(1, 9);
      if ($urandom_range(0, 29) == 0) fr = ~fr;
      st = ($urandom_range(0, 399) == 0);
      cv = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 9) < bias);
      tick(st, fr, cv, c, 16'($urandom));
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        if (bad < 30) $display("[TB] FAIL random[%0d] got=%h want=%h", n, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_preset();
    test_acq_gear();
    test_lock();
    test_track_vote();
    test_loss();
    test_freeze();
    test_start_mid_track();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
